// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction fields,
// flag positions and FSM states.
package alu_issue_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1100;
    localparam logic [3:0] OP_AND = 4'b1110;

    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 6;
    localparam int RS1_MSB = 5;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 2;

    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
               (op == OP_OR)  || (op == OP_AND);
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 4-entry register file: one synchronous write port, two asynchronous read ports,
// cleared by synchronous reset.
module alu_issue_regfile
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [1:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [1:0]   raddr_a,
    output logic [W-1:0] rdata_a,
    input  logic [1:0]   raddr_b,
    output logic [W-1:0] rdata_b
);

    logic [W-1:0] rf [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= '0;
            end
        end else if (we) begin
            rf[waddr] <= wdata;
        end
    end

    assign rdata_a = rf[raddr_a];
    assign rdata_b = rf[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Operand/issue stage for the 4-bit ALU: reads operands, drives the ALU, waits out
// its latency, then writes the result back and latches the flags.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int W       = 4,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [11:0]  instr,
    input  logic         ld_en,
    input  logic [1:0]   ld_addr,
    input  logic [W-1:0] ld_data,
    output logic [W-1:0] alu_A,
    output logic [W-1:0] alu_B,
    output logic [3:0]   alu_G_sel,
    input  logic [W-1:0] alu_G,
    input  logic [3:0]   alu_flags,
    output logic         wb_valid,
    output logic [1:0]   wb_rd,
    output logic [W-1:0] wb_data,
    output logic [3:0]   flags_q,
    output logic         err_illegal,
    output logic         busy
);

    localparam logic [2:0] LAT_CNT = 3'(ALU_LAT);

    state_t       state, state_n;
    logic [2:0]   cnt, cnt_n;
    logic [1:0]   rd_q;
    logic [3:0]   op;
    logic [1:0]   rd, rs1, rs2;
    logic         legal, accept, done;
    logic         rf_we;
    logic [1:0]   rf_waddr;
    logic [W-1:0] rf_wdata, rs1_data, rs2_data;
    logic [1:0]   unused_reserved;

    assign op              = instr[OP_MSB:OP_LSB];
    assign rd              = instr[RD_MSB:RD_LSB];
    assign rs1             = instr[RS1_MSB:RS1_LSB];
    assign rs2             = instr[RS2_MSB:RS2_LSB];
    assign unused_reserved = instr[1:0];

    assign legal       = is_legal_op(op);
    // A pending load steals the IDLE cycle, so the instruction waits one more cycle.
    assign instr_ready = (state == IDLE) && !ld_en && !reset;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state != IDLE);

    assign rf_we    = done || ((state == IDLE) && ld_en);
    assign rf_waddr = done ? rd_q  : ld_addr;
    assign rf_wdata = done ? alu_G : ld_data;

    alu_issue_regfile #(.W(W)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs1),
        .rdata_a (rs1_data),
        .raddr_b (rs2),
        .rdata_b (rs2_data)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && legal) begin
                    state_n = EXEC;
                    cnt_n   = 3'd0;
                end
            end
            EXEC: begin
                cnt_n = cnt + 3'd1;
                if (cnt == LAT_CNT) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // ALU drive holds its last legal instruction; it is never cleared except by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_A       <= '0;
            alu_B       <= '0;
            alu_G_sel   <= 4'b0000;
            rd_q        <= 2'd0;
            wb_valid    <= 1'b0;
            wb_rd       <= 2'd0;
            wb_data     <= '0;
            flags_q     <= 4'b0000;
            err_illegal <= 1'b0;
        end else begin
            wb_valid    <= done;
            err_illegal <= accept && !legal;
            if (accept && legal) begin
                alu_A     <= rs1_data;
                alu_B     <= rs2_data;
                alu_G_sel <= op;
                rd_q      <= rd;
            end
            if (done) begin
                wb_rd   <= rd_q;
                wb_data <= alu_G;
                flags_q <= alu_flags;
            end
        end
    end

endmodule
